// File: rtl/home_event_scheduler_pkg.sv
// Shared types and constants for the home-automation event scheduler.
// Source ids double as bit positions in the pending bitmap.
package home_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    HOLD
  } state_t;

  localparam int NUM_SRC = 5;

  localparam logic [2:0] SRC_S0   = 3'd0;
  localparam logic [2:0] SRC_S1   = 3'd1;
  localparam logic [2:0] SRC_S2   = 3'd2;
  localparam logic [2:0] SRC_S3   = 3'd3;
  localparam logic [2:0] SRC_TEMP = 3'd4;

  function automatic logic [NUM_SRC-1:0] src_onehot(input logic [2:0] id);
    return NUM_SRC'(1) << id;
  endfunction

endpackage

// File: rtl/home_event_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin picker: grants the first requester found
// searching upward from ptr, wrapping 3 -> 0.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_id,
  output logic       any
);

  logic [1:0] idx;

  always_comb begin
    gnt_id = ptr;
    idx    = ptr;
    any    = |req;
    // Walk from the farthest offset back to ptr so the nearest requester wins.
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        gnt_id = idx;
      end
    end
  end

endmodule

// File: rtl/home_event_scheduler.sv
// Turns sensor rising edges and temperature alarms into serialized service
// requests over valid/ready, with a minimum hold gap between services.
module home_event_scheduler
  import home_sched_pkg::*;
#(
  parameter int          HOLD_CYCLES = 8,
  parameter logic [5:0]  TEMP_HI     = 6'd40,
  parameter int          DROP_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        sensors,
  input  logic [5:0]        temp,
  output logic              svc_valid,
  output logic [2:0]        svc_id,
  input  logic              svc_ready,
  output logic [4:0]        pending,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [3:0]          sens_q;
  logic                hot_q;
  logic [4:0]          pending_reg, pending_next;
  logic [DROP_W-1:0]   drop_reg, drop_next;
  logic [2:0]          svc_id_reg, svc_id_next;
  logic [1:0]          rr_reg, rr_next;
  logic [HW-1:0]       hold_reg, hold_next;

  logic                hot;
  logic [4:0]          ev;
  logic [4:0]          clr;
  logic                accept;
  logic [1:0]          gnt_id;
  logic                gnt_any;

  rr_arbiter4 u_rr (
    .req    (pending_reg[3:0]),
    .ptr    (rr_reg),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  assign hot    = (temp >= TEMP_HI);
  assign ev     = {hot & ~hot_q, sensors & ~sens_q};
  assign accept = (state_reg == OFFER) && svc_ready;
  assign clr    = accept ? src_onehot(svc_id_reg) : '0;

  // A fresh event re-pends its source even if that source is being cleared.
  always_comb begin
    pending_next = (pending_reg & ~clr) | ev;
    drop_next    = drop_reg;
    if ((|(ev & pending_reg & ~clr)) && (drop_reg != '1)) begin
      drop_next = drop_reg + DROP_W'(1);
    end
  end

  always_comb begin
    state_next  = state_reg;
    svc_id_next = svc_id_reg;
    rr_next     = rr_reg;
    hold_next   = hold_reg;
    case (state_reg)
      IDLE: begin
        if (|pending_reg) begin
          svc_id_next = pending_reg[SRC_TEMP] ? SRC_TEMP : {1'b0, gnt_id};
          state_next  = OFFER;
        end
      end
      OFFER: begin
        if (svc_ready) begin
          hold_next  = HOLD_LOAD;
          state_next = HOLD;
          if (svc_id_reg != SRC_TEMP) begin
            rr_next = svc_id_reg[1:0] + 2'd1;
          end
        end
      end
      HOLD: begin
        if (hold_reg == '0) begin
          state_next = IDLE;
        end else begin
          hold_next = hold_reg - HW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      sens_q      <= '0;
      hot_q       <= 1'b0;
      pending_reg <= '0;
      drop_reg    <= '0;
      svc_id_reg  <= '0;
      rr_reg      <= '0;
      hold_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      sens_q      <= sensors;
      hot_q       <= hot;
      pending_reg <= pending_next;
      drop_reg    <= drop_next;
      svc_id_reg  <= svc_id_next;
      rr_reg      <= rr_next;
      hold_reg    <= hold_next;
    end
  end

  assign svc_valid = (state_reg == OFFER);
  assign busy      = (state_reg != IDLE);
  assign svc_id    = svc_id_reg;
  assign pending   = pending_reg;
  assign drop_cnt  = drop_reg;

endmodule

// File: tb/tb_home_event_scheduler.sv
// Self-checking bench for home_event_scheduler: directed scenarios plus a
// randomized run against a timestamp-based reference model.
module tb_home_event_scheduler;

  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sensors = '0;
  logic [5:0] temp = '0;
  logic       svc_ready = 1'b0;
  logic       svc_valid;
  logic [2:0] svc_id;
  logic [4:0] pending;
  logic       busy;
  logic [7:0] drop_cnt;

  home_event_scheduler #(
    .HOLD_CYCLES (HOLD),
    .TEMP_HI     (6'd40),
    .DROP_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sensors   (sensors),
    .temp      (temp),
    .svc_valid (svc_valid),
    .svc_id    (svc_id),
    .svc_ready (svc_ready),
    .pending   (pending),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: offer flag, pending set, and the edge index of the last
  // accept; the hold gap is derived from timestamps.
  int         cyc = 0;
  logic [3:0] m_sq;
  logic       m_hq;
  logic [4:0] m_pend;
  int         m_drop;
  logic       m_valid;
  int         m_id;
  int         m_rr;
  int         m_last_acc;
  logic       m_busy;

  task automatic model_reset();
    m_sq = '0; m_hq = 1'b0; m_pend = '0; m_drop = 0;
    m_valid = 1'b0; m_id = 0; m_rr = 0; m_last_acc = -1000; m_busy = 1'b0;
  endtask

  task automatic step();
    logic [4:0] ev;
    logic [4:0] clr;
    logic       hot;
    bit         found;
    @(posedge clk);
    cyc++;
    hot = (temp >= 6'd40);
    ev  = {hot & ~m_hq, sensors & ~m_sq};
    clr = '0;
    if (m_valid && svc_ready) begin
      clr[m_id]  = 1'b1;
      m_valid    = 1'b0;
      m_last_acc = cyc;
      if (m_id < 4) m_rr = (m_id + 1) % 4;
    end else if (!m_valid && (cyc > m_last_acc + HOLD) && (m_pend != 0)) begin
      m_valid = 1'b1;
      if (m_pend[4]) begin
        m_id = 4;
      end else begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && m_pend[(m_rr + k) % 4]) begin
            m_id  = (m_rr + k) % 4;
            found = 1;
          end
        end
      end
    end
    if (((ev & m_pend & ~clr) != 0) && (m_drop < 255)) m_drop++;
    m_pend = (m_pend & ~clr) | ev;
    m_sq   = sensors;
    m_hq   = hot;
    m_busy = m_valid || (cyc < m_last_acc + HOLD);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    sensors = 4'b1111; temp = 6'd50; svc_ready = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({svc_valid, svc_id, pending, busy} !== 10'd0 || drop_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: valid=%0b id=%0d pend=%b busy=%0b drop=%0d, required all 0",
               svc_valid, svc_id, pending, busy, drop_cnt);
    end
    $display("test_reset: outputs held at zero during reset");
  endtask

  task automatic test_single();
    int bc;
    sensors = 4'b0010; temp = 6'd20; svc_ready = 1'b1;
    do_reset();
    step();
    n_cmp++;
    if (pending !== 5'b00010 || svc_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_e0: pend=%b valid=%0b, required pend=00010 valid=0", pending, svc_valid);
    end
    step();
    n_cmp++;
    if (svc_valid !== 1'b1 || svc_id !== 3'd1) begin
      n_bad++;
      $display("FAIL single_e1: valid=%0b id=%0d, required valid=1 id=1", svc_valid, svc_id);
    end
    step();
    n_cmp++;
    if (svc_valid !== 1'b0 || pending !== 5'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_accept: valid=%0b pend=%b busy=%0b, required 0/00000/1", svc_valid, pending, busy);
    end
    bc = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy) bc++;
      else break;
    end
    n_cmp++;
    if (bc != HOLD) begin
      n_bad++;
      $display("FAIL single_hold_len: busy cycles=%0d, required %0d", bc, HOLD);
    end
    $display("test_single: id=1 accepted, hold busy cycles=%0d", bc);
    sensors = 4'b0000;
  endtask

  task automatic test_rr();
    int ids[3];
    int acc[3];
    int exp_ids[3];
    int got;
    exp_ids[0] = 0; exp_ids[1] = 1; exp_ids[2] = 3;
    sensors = 4'b0000; temp = 6'd20; svc_ready = 1'b1;
    do_reset();
    step();
    sensors = 4'b1011;
    got = 0;
    for (int i = 0; i < 80 && got < 3; i++) begin
      if (svc_valid) begin
        ids[got] = svc_id;
        acc[got] = cyc + 1;
        got++;
      end
      step();
    end
    n_cmp++;
    if (got != 3) begin
      n_bad++;
      $display("FAIL rr_count: grants=%0d, required 3", got);
    end else begin
      for (int g = 0; g < 3; g++) begin
        n_cmp++;
        if (ids[g] != exp_ids[g]) begin
          n_bad++;
          $display("FAIL rr_order[%0d]: id=%0d, required %0d", g, ids[g], exp_ids[g]);
        end
        $display("test_rr: grant %0d id=%0d at edge %0d", g, ids[g], acc[g]);
      end
      n_cmp++;
      if (acc[1] - acc[0] != HOLD + 2 || acc[2] - acc[1] != HOLD + 2) begin
        n_bad++;
        $display("FAIL rr_spacing: gaps=%0d,%0d, required %0d", acc[1] - acc[0], acc[2] - acc[1], HOLD + 2);
      end
    end
    sensors = 4'b0000;
  endtask

  task automatic test_no_preempt();
    sensors = 4'b0000; temp = 6'd39; svc_ready = 1'b0;
    do_reset();
    step();
    sensors = 4'b0101;
    for (int i = 0; i < 10 && !svc_valid; i++) step();
    n_cmp++;
    if (svc_valid !== 1'b1 || svc_id !== 3'd0) begin
      n_bad++;
      $display("FAIL preempt_first: valid=%0b id=%0d, required 1/0", svc_valid, svc_id);
    end
    temp = 6'd45;
    step(); step();
    n_cmp++;
    if (svc_valid !== 1'b1 || svc_id !== 3'd0 || pending[4] !== 1'b1) begin
      n_bad++;
      $display("FAIL preempt_hold: valid=%0b id=%0d pend=%b, required 1/0/1xxxx", svc_valid, svc_id, pending);
    end
    svc_ready = 1'b1;
    step();
    for (int i = 0; i < 20 && !svc_valid; i++) step();
    n_cmp++;
    if (svc_valid !== 1'b1 || svc_id !== 3'd4 || pending[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL preempt_next: valid=%0b id=%0d pend=%b, required 1/4/x1xx", svc_valid, svc_id, pending);
    end
    $display("test_no_preempt: second offer id=%0d pend=%b", svc_id, pending);
    sensors = 4'b0000; temp = 6'd20;
  endtask

  task automatic test_stall();
    logic [2:0] id0;
    sensors = 4'b0000; temp = 6'd20; svc_ready = 1'b0;
    do_reset();
    step();
    sensors = 4'b1000;
    for (int i = 0; i < 10 && !svc_valid; i++) step();
    id0 = svc_id;
    n_cmp++;
    if (svc_valid !== 1'b1 || id0 !== 3'd3) begin
      n_bad++;
      $display("FAIL stall_offer: valid=%0b id=%0d, required 1/3", svc_valid, id0);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (svc_valid !== 1'b1 || svc_id !== 3'd3) begin
        n_bad++;
        $display("FAIL stall_cycle%0d: valid=%0b id=%0d, required 1/3", i, svc_valid, svc_id);
      end
    end
    svc_ready = 1'b1;
    step();
    n_cmp++;
    if (svc_valid !== 1'b0 || pending[3] !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_accept: valid=%0b pend=%b busy=%0b, required 0/0xxx/1", svc_valid, pending, busy);
    end
    $display("test_stall: held 20 cycles then accepted id=3");
    sensors = 4'b0000;
  endtask

  task automatic test_drop();
    sensors = 4'b0000; temp = 6'd20; svc_ready = 1'b0;
    do_reset();
    step();
    sensors = 4'b0010;
    for (int i = 0; i < 10 && !svc_valid; i++) step();
    sensors = 4'b0011; step();
    sensors = 4'b0010; step();
    sensors = 4'b0011; step();
    n_cmp++;
    if (drop_cnt !== 8'd1 || pending[0] !== 1'b1 || int'(drop_cnt) != m_drop) begin
      n_bad++;
      $display("FAIL drop_one: drop=%0d pend=%b, required drop=1 pend[0]=1", drop_cnt, pending);
    end
    for (int i = 0; i < 300; i++) begin
      sensors = 4'b0010; step();
      sensors = 4'b0011; step();
    end
    n_cmp++;
    if (drop_cnt !== 8'd255 || svc_id !== 3'd1) begin
      n_bad++;
      $display("FAIL drop_sat: drop=%0d id=%0d, required 255/1", drop_cnt, svc_id);
    end
    $display("test_drop: drop_cnt=%0d after saturation", drop_cnt);
    sensors = 4'b0000;
  endtask

  task automatic test_reset_mid_hold();
    sensors = 4'b0000; temp = 6'd20; svc_ready = 1'b1;
    do_reset();
    step();
    sensors = 4'b0101;
    for (int i = 0; i < 10 && !(busy && !svc_valid); i++) step();
    step();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (svc_valid !== 1'b0 || pending !== 5'b0 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL async_reset: valid=%0b pend=%b busy=%0b drop=%0d, required all 0",
               svc_valid, pending, busy, drop_cnt);
    end
    @(negedge clk) rst = 1'b1;
    model_reset();
    step();
    n_cmp++;
    if (pending !== 5'b00101 || busy !== 1'b0 || pending !== m_pend) begin
      n_bad++;
      $display("FAIL reset_release: pend=%b busy=%0b, required pend=00101 busy=0", pending, busy);
    end
    $display("test_reset_mid_hold: cleared asynchronously, pend=%b after release", pending);
    sensors = 4'b0000;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    sensors = 4'b0000; temp = 6'd30; svc_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 3) sensors = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 2) temp = 6'($urandom_range(30, 50));
      svc_ready = ($urandom_range(0, 2) != 0);
      step();
      n_cmp++;
      if (svc_valid !== m_valid || svc_id !== 3'(m_id) || pending !== m_pend ||
          busy !== m_busy || int'(drop_cnt) != m_drop) begin
        n_bad++;
        errs++;
        $display("FAIL random_c%0d: valid=%0b id=%0d pend=%b busy=%0b drop=%0d, required %0b/%0d/%b/%0b/%0d",
                 i, svc_valid, svc_id, pending, busy, drop_cnt, m_valid, m_id, m_pend, m_busy, m_drop);
      end
    end
    $display("test_random: 800 cycles, %0d disagreements, drop=%0d", errs, drop_cnt);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rr();
    test_no_preempt();
    test_stall();
    test_drop();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/home_event_scheduler.md
Name: home_event_scheduler

Overview:
- Front-end controller for the home-automation FSM: turns raw sensor and temperature inputs into single, serialized service requests.
- Captures sensor rising edges and temperature threshold crossings as pending events, arbitrates among them, and offers one event at a time over a valid/ready handshake.
- Enforces a minimum hold gap between consecutive services.
- Sits between the board inputs (sensors, temp) and the automation FSM.

Parameters:
- HOLD_CYCLES, 8, idle cycles enforced after each accepted service (>=1).
- TEMP_HI, 6'd40, temperature alarm threshold; alarm condition is temp >= TEMP_HI (unsigned).
- DROP_W, 8, width of the saturating dropped-event counter.

Ports:
- clk, input, 1, single system clock, rising edge.
- rst, input, 1, asynchronous active-low reset (0 = reset).
- sensors, input, 4, raw sensor levels, synchronous to clk.
- temp, input, 6, unsigned temperature reading, synchronous to clk.
- svc_valid, output, 1, an event is offered to the FSM.
- svc_id, output, 3, offered source: 0-3 = sensors[0..3], 4 = temp alarm; stable while svc_valid=1.
- svc_ready, input, 1, FSM accepts the offered event.
- pending, output, 5, registered pending bitmap: bit i = source i, bit 4 = temp.
- busy, output, 1, 1 in OFFER or HOLD.
- drop_cnt, output, DROP_W, saturating count of events lost because their source was already pending.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; svc_valid=0, svc_id=0, pending=0, busy=0, drop_cnt=0.
  - rr_ptr=0, hold counter=0, edge-history registers=0.
  - A sensor already high, or temp >= TEMP_HI, at reset release therefore registers one event on the first clock edge.
- Event detection, per clock edge:
  - ev[i] = sensors[i] & ~sens_q[i] for i=0..3.
  - ev[4] = (temp>=TEMP_HI) & ~hot_q.
  - sens_q and hot_q update every cycle.
- Pending update: pending_next = (pending & ~clr) | ev.
  - Set beats clear: an event on the source being cleared in the same cycle re-pends it.
  - If ev[i]=1 and pending[i]=1 and not cleared that cycle, drop_cnt increments, saturating at all-ones. Multiple simultaneous drops add only +1 per cycle.
- Arbitration (IDLE only, on the registered pending):
  - Bit 4 (temp) has fixed highest priority.
  - Else round-robin over bits 0..3, searching from rr_ptr upward with wrap 3->0.
- State machine:
  - IDLE: if pending!=0, latch the winner into svc_id, set svc_valid=1, go OFFER. Else stay.
  - OFFER: hold svc_valid=1 and svc_id constant until svc_ready=1.
    - On the cycle with svc_valid&svc_ready: clr=onehot(svc_id); svc_valid->0; hold counter loads HOLD_CYCLES-1; go HOLD.
    - If svc_id<4, rr_ptr=(svc_id+1) mod 4; the temp grant leaves rr_ptr unchanged.
  - HOLD: svc_valid=0; decrement the counter each cycle; when the counter is 0, go IDLE. IDLE may re-offer on the following edge.
- Arbitration cannot preempt: a temp event arriving during OFFER does not replace the current offer.
- svc_ready while svc_valid=0 is ignored.
- Latency: sensor first sampled high at edge E0 -> pending bit visible after E0 -> svc_valid=1 after E1.
- Spacing: minimum distance between accepting handshakes is HOLD_CYCLES+2 cycles. With HOLD_CYCLES=8, accept at edge A means the next accept is at A+10 at the earliest, with svc_ready held high.
- Reset asserted mid-OFFER or mid-HOLD drops all pending events and the offer immediately, without waiting for a clock.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package home_sched_pkg:
  - State enum {IDLE, OFFER, HOLD}.
  - Source ID constants SRC_S0..SRC_S3=0..3, SRC_TEMP=4.
  - NUM_SRC=5.
- Sub-module rr_arbiter4: combinational 4-way round-robin picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: gnt_id[1:0], any.
- Top block holds edge detection, pending/drop logic, the FSM and the hold counter.

Test Plan:
- Reset then sensors=4'b0010, svc_ready=1 -> pending=5'b00010 after E0; svc_valid=1 with svc_id=1 after E1; accepted; pending=0; busy=1 for HOLD_CYCLES cycles.
- sensors 4'b0000->4'b1011 in one cycle, svc_ready=1, rr_ptr=0 -> grants in order id 0, 1, 3, each accept 10 cycles apart.
- Sensor 2 pending in OFFER while temp goes 39->45 -> the current offer completes first; the next offer is svc_id=4 even though bit 2 remains pending.
- svc_ready=0 for 20 cycles during OFFER -> svc_valid and svc_id stay constant; svc_ready=1 accepts in that same cycle.
- Toggle sensors[0] 0->1->0->1 while bit 0 is pending, not granted -> drop_cnt=1; pending[0] stays 1. Repeat 300 drops -> drop_cnt saturates at 255.
- Assert rst low mid-HOLD, asynchronously between edges -> svc_valid, pending, busy and drop_cnt go 0 immediately; state IDLE after release.
